// File: rtl/mtl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mtl_pkg
// Purpose  : Shared timing defaults, RGB888 type and colour-bar constants
//            for the scan composer.
// Revision : 1.0 - initial release
// ============================================================================
package mtl_pkg;

  // Default 800x480 panel timing (pixel clocks / lines)
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 210;
  localparam int H_SYNC_DEF   = 20;
  localparam int H_BP_DEF     = 26;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 22;
  localparam int V_SYNC_DEF   = 10;
  localparam int V_BP_DEF     = 13;
  localparam int FACE_LAT_DEF = 2;

  typedef logic [23:0] rgb_t;

  // Colour bars, left to right
  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  // Map a bar index (0 = leftmost) to its colour
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtl_delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mtl_delay_line
// Purpose  : WIDTH-bit, DEPTH-stage shift register with synchronous
//            active-low clear; DEPTH = 0 degenerates to a plain wire.
// Revision : 1.0 - initial release
// ============================================================================
module mtl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock and reset have no job when there is no storage
      logic unused_ports;
      assign unused_ports = clk ^ reset;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      // Shift din through DEPTH registers; reset clears every stage
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mtl_scan_composer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mtl_scan_composer
// Purpose  : Raster timing generator and priority pixel composer. Counters
//            drive the cube generators; their face flags return FACE_LAT
//            clocks later and are merged into a registered RGB output with
//            syncs/de delayed to match.
// Options  : TEST_PATTERN_EN - adds test_mode input selecting 8 colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module mtl_scan_composer
  import mtl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int FACE_LAT = FACE_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  input  logic        top_face,
  input  logic        left_face,
  input  logic        right_face,
  input  logic        qbert_top_face,
  input  logic [23:0] col_top,
  input  logic [23:0] col_left,
  input  logic [23:0] col_right,
  input  logic [23:0] col_qbert,
  input  logic [23:0] col_bg,
`ifdef TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start,
  output logic        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic raw_vis, raw_hs, raw_vs;
  logic vis_d, hs_d, vs_d;
  rgb_t next_rgb;

  // Raster counters; a mid-frame reset drops straight back to (0,0)
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_cnt == H_LAST) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == V_LAST) ? 10'd0 : y_cnt + 10'd1;
    end else begin
      x_cnt <= x_cnt + 11'd1;
    end
  end

  // Undelayed decode of visibility and sync windows
  always_comb begin
    raw_vis = (x_cnt < H_VIS_END) && (y_cnt < V_VIS_END);
    raw_hs  = (x_cnt >= HS_START) && (x_cnt < HS_END);
    raw_vs  = (y_cnt >= VS_START) && (y_cnt < VS_END);
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx, bar_idx_d;

  // Bar index = number of bar boundaries already passed on this line
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x_cnt >= 11'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  mtl_delay_line #(.WIDTH(6), .DEPTH(FACE_LAT)) u_align (
    .clk   (clk),
    .reset (reset),
    .din   ({bar_idx, raw_vis, raw_hs, raw_vs}),
    .dout  ({bar_idx_d, vis_d, hs_d, vs_d})
  );
`else
  mtl_delay_line #(.WIDTH(3), .DEPTH(FACE_LAT)) u_align (
    .clk   (clk),
    .reset (reset),
    .din   ({raw_vis, raw_hs, raw_vs}),
    .dout  ({vis_d, hs_d, vs_d})
  );
`endif

  // Pixel selection: fixed face priority, blanked outside the visible area
  always_comb begin
    if (qbert_top_face)  next_rgb = col_qbert;
    else if (top_face)   next_rgb = col_top;
    else if (left_face)  next_rgb = col_left;
    else if (right_face) next_rgb = col_right;
    else                 next_rgb = col_bg;
`ifdef TEST_PATTERN_EN
    if (test_mode) next_rgb = bar_colour(bar_idx_d);
`endif
    if (!vis_d) next_rgb = '0;
  end

  // Registered video output stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      de      <= 1'b0;
      rgb     <= '0;
    end else begin
      hsync_n <= ~hs_d;
      vsync_n <= ~vs_d;
      de      <= vis_d;
      rgb     <= next_rgb;
    end
  end

  // Frame markers decoded from the undelayed counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= (x_cnt == 11'd0) && (y_cnt == 10'd0);
      vblank      <= (y_cnt >= V_VIS_END);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mtl_scan_composer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mtl_scan_composer
// Purpose  : Directed self-checking bench. Horizontal timing is the default
//            1056-clock line; the frame is shortened to 56 lines (52 visible)
//            so a full frame wrap fits a short run.
// Options  : TEST_PATTERN_EN - also exercises the colour-bar mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtl_scan_composer;

  localparam int LAT       = 2;
  localparam int V_ACT     = 52;
  localparam int V_TOT     = 56;
  localparam int FRAME_CLK = 1056 * V_TOT;
  localparam int BUDGET    = 70000;

  localparam logic [23:0] COL_TOP   = 24'h112233;
  localparam logic [23:0] COL_LEFT  = 24'h445566;
  localparam logic [23:0] COL_RIGHT = 24'h778899;
  localparam logic [23:0] COL_QBERT = 24'hAABBCC;
  localparam logic [23:0] COL_BG    = 24'h0D0E0F;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        top_face, left_face, right_face, qbert_top_face;
  logic [23:0] col_top, col_left, col_right, col_qbert, col_bg;
`ifdef TEST_PATTERN_EN
  logic        test_mode;
`endif
  logic        hsync_n, vsync_n, de, frame_start, vblank;
  logic [23:0] rgb;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int first_fs_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mtl_scan_composer #(
    .V_ACTIVE (V_ACT),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .FACE_LAT (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .x_cnt          (x_cnt),
    .y_cnt          (y_cnt),
    .top_face       (top_face),
    .left_face      (left_face),
    .right_face     (right_face),
    .qbert_top_face (qbert_top_face),
    .col_top        (col_top),
    .col_left       (col_left),
    .col_right      (col_right),
    .col_qbert      (col_qbert),
    .col_bg         (col_bg),
`ifdef TEST_PATTERN_EN
    .test_mode      (test_mode),
`endif
    .hsync_n        (hsync_n),
    .vsync_n        (vsync_n),
    .de             (de),
    .rgb            (rgb),
    .frame_start    (frame_start),
    .vblank         (vblank)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the counters show (x,y); overrunning the budget is a failure
  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(x_cnt == 11'(x) && y_cnt == 10'(y)) && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) begin
      checks++; errors++;
      $display("FAIL wait_xy: never reached (%0d,%0d), stuck at (%0d,%0d)", x, y, x_cnt, y_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (x_cnt !== 11'd0) begin errors++; $display("FAIL rst_x: got %0d want 0", x_cnt); end
    checks++; if (y_cnt !== 10'd0) begin errors++; $display("FAIL rst_y: got %0d want 0", y_cnt); end
    checks++; if (hsync_n !== 1'b1) begin errors++; $display("FAIL rst_hsync_n: got %b want 1", hsync_n); end
    checks++; if (vsync_n !== 1'b1) begin errors++; $display("FAIL rst_vsync_n: got %b want 1", vsync_n); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL rst_de: got %b want 0", de); end
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL rst_rgb: got %h want 000000", rgb); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    checks++; if (vblank !== 1'b0) begin errors++; $display("FAIL rst_vblank: got %b want 0", vblank); end
    reset = 1'b1;
    tick();
    checks++; if (x_cnt !== 11'd1) begin errors++; $display("FAIL rel_x: got %0d want 1", x_cnt); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rel_frame_start: got %b want 1", frame_start); end
    first_fs_cyc = cyc;
    tick();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_width: got %b want 0", frame_start); end
  endtask

  task automatic test_hsync();
    int lows = 0;
    int first = -1;
    wait_xy(1010, 0);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (hsync_n === 1'b0) begin
        lows++;
        if (first < 0) first = n;
      end
    end
    checks++; if (lows != 20) begin errors++; $display("FAIL hsync_width: got %0d want 20", lows); end
    checks++; if (first != LAT + 1) begin errors++; $display("FAIL hsync_delay: got %0d want %0d", first, LAT + 1); end
  endtask

  task automatic test_de_line();
    int highs = 0;
    int first = -1;
    int bad = 0;
    wait_xy(0, 1);
    for (int n = 1; n <= 1056; n++) begin
      tick();
      if (de === 1'b1) begin
        highs++;
        if (first < 0) first = n;
        if (rgb !== COL_BG) bad++;
      end else if (rgb !== 24'h0) begin
        bad++;
      end
    end
    checks++; if (highs != 800) begin errors++; $display("FAIL de_count: got %0d want 800", highs); end
    checks++; if (first != LAT + 1) begin errors++; $display("FAIL de_delay: got %0d want %0d", first, LAT + 1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bg_fill: %0d bad pixels, want 0", bad); end
  endtask

  task automatic test_blanking();
    wait_xy(900 + LAT, 2);
    left_face = 1'b1;
    tick();
    left_face = 1'b0;
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL blank_rgb: got %h want 000000", rgb); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL blank_de: got %b want 0", de); end
  endtask

  task automatic test_priority();
    wait_xy(100 + LAT, 50);
    top_face = 1'b1; qbert_top_face = 1'b1;
    tick();
    checks++; if (rgb !== COL_QBERT) begin errors++; $display("FAIL prio_qbert: got %h want %h", rgb, COL_QBERT); end
    qbert_top_face = 1'b0;
    tick();
    checks++; if (rgb !== COL_TOP) begin errors++; $display("FAIL prio_top: got %h want %h", rgb, COL_TOP); end
    top_face = 1'b0; left_face = 1'b1; right_face = 1'b1;
    tick();
    checks++; if (rgb !== COL_LEFT) begin errors++; $display("FAIL prio_left: got %h want %h", rgb, COL_LEFT); end
    left_face = 1'b0;
    tick();
    checks++; if (rgb !== COL_RIGHT) begin errors++; $display("FAIL prio_right: got %h want %h", rgb, COL_RIGHT); end
    right_face = 1'b0;
    tick();
    checks++; if (rgb !== COL_BG) begin errors++; $display("FAIL prio_bg: got %h want %h", rgb, COL_BG); end
  endtask

  task automatic test_vertical();
    wait_xy(0, V_ACT);
    checks++; if (vblank !== 1'b0) begin errors++; $display("FAIL vblank_pre: got %b want 0", vblank); end
    tick();
    checks++; if (vblank !== 1'b1) begin errors++; $display("FAIL vblank_on: got %b want 1", vblank); end
    wait_xy(LAT, V_ACT + 1);
    checks++; if (vsync_n !== 1'b1) begin errors++; $display("FAIL vsync_pre: got %b want 1", vsync_n); end
    tick();
    checks++; if (vsync_n !== 1'b0) begin errors++; $display("FAIL vsync_on: got %b want 0", vsync_n); end
  endtask

  task automatic test_frame_wrap();
    wait_xy(1055, V_TOT - 1);
    tick();
    checks++; if (x_cnt !== 11'd0 || y_cnt !== 10'd0) begin
      errors++; $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", x_cnt, y_cnt);
    end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_again: got %b want 1", frame_start); end
    checks++; if (cyc - first_fs_cyc != FRAME_CLK) begin
      errors++; $display("FAIL fs_period: got %0d want %0d", cyc - first_fs_cyc, FRAME_CLK);
    end
  endtask

  task automatic test_midframe_reset();
    wait_xy(400, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (x_cnt !== 11'd0) begin errors++; $display("FAIL mid_x: got %0d want 0", x_cnt); end
    checks++; if (y_cnt !== 10'd0) begin errors++; $display("FAIL mid_y: got %0d want 0", y_cnt); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL mid_de: got %b want 0", de); end
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL mid_rgb: got %h want 000000", rgb); end
    checks++; if (hsync_n !== 1'b1 || vsync_n !== 1'b1) begin
      errors++; $display("FAIL mid_sync: got %b%b want 11", hsync_n, vsync_n);
    end
    checks++; if (frame_start !== 1'b0 || vblank !== 1'b0) begin
      errors++; $display("FAIL mid_flags: got fs=%b vb=%b want 0 0", frame_start, vblank);
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    test_mode = 1'b1;
    qbert_top_face = 1'b1;
    wait_xy(0 + LAT + 1, 0);
    checks++; if (rgb !== 24'hFFFFFF) begin errors++; $display("FAIL bar_x0: got %h want FFFFFF", rgb); end
    wait_xy(100 + LAT + 1, 0);
    checks++; if (rgb !== 24'hFFFF00) begin errors++; $display("FAIL bar_x100: got %h want FFFF00", rgb); end
    wait_xy(300 + LAT + 1, 0);
    checks++; if (rgb !== 24'h00FF00) begin errors++; $display("FAIL bar_x300: got %h want 00FF00", rgb); end
    wait_xy(799 + LAT + 1, 0);
    checks++; if (rgb !== 24'h000000 || de !== 1'b1) begin
      errors++; $display("FAIL bar_x799: got %h de=%b want 000000 de=1", rgb, de);
    end
    test_mode = 1'b0;
    qbert_top_face = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    top_face = 1'b0; left_face = 1'b0; right_face = 1'b0; qbert_top_face = 1'b0;
    col_top = COL_TOP; col_left = COL_LEFT; col_right = COL_RIGHT;
    col_qbert = COL_QBERT; col_bg = COL_BG;
`ifdef TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    test_reset();
    test_hsync();
    test_de_line();
    test_blanking();
    test_priority();
    test_vertical();
    test_frame_wrap();
    test_midframe_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mtl_scan_composer.md
MTL_SCAN_COMPOSER -- requirements
Module: mtl_scan_composer

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter H_FP, 210, horizontal front porch, in clocks.
REQ-003 Parameter H_SYNC, 20, hsync pulse width, in clocks.
REQ-004 Parameter H_BP, 26, horizontal back porch; H_TOTAL = sum of the four H values = 1056.
REQ-005 Parameters V_ACTIVE 480, V_FP 22, V_SYNC 10, V_BP 13; lines per frame V_TOTAL = 525.
REQ-006 Parameter FACE_LAT, 2, clocks from x_cnt/y_cnt to valid face flags (range 0..7).
REQ-007 clk  in  1  pixel clock; the only clock.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 x_cnt  out  11  horizontal position, 0..H_TOTAL-1.
REQ-010 y_cnt  out  10  vertical position, 0..V_TOTAL-1.
REQ-011 top_face, left_face, right_face, qbert_top_face  in  1 each  face flags from the cube generators, already ORed across cubes.
REQ-012 col_top, col_left, col_right, col_qbert, col_bg  in  24 each  RGB888 colours; sampled every clock.
REQ-013 hsync_n, vsync_n  out  1  active-low syncs.
REQ-014 de  out  1  data enable, high for visible pixels.
REQ-015 rgb  out  24  composed pixel.
REQ-016 frame_start  out  1  one-clock pulse when x_cnt=0 and y_cnt=0.
REQ-017 vblank  out  1  high while y_cnt >= V_ACTIVE; game logic updates offsets only during vblank.

Function
REQ-018 x_cnt increments every clock and wraps from H_TOTAL-1 to 0; y_cnt increments on each x wrap and wraps from V_TOTAL-1 to 0 on the same clock that x wraps.
REQ-019 Raw sync/visibility are decoded from the counters: visible when x_cnt<H_ACTIVE and y_cnt<V_ACTIVE.
REQ-020 Sync windows: hsync active for H_ACTIVE+H_FP <= x_cnt < H_ACTIVE+H_FP+H_SYNC; vsync uses the equivalent vertical window.
REQ-021 Raw visible, hsync and vsync pass through a FACE_LAT-stage shift register so that they align with the incoming face flags.
REQ-022 The output stage is registered; total latency from the counter value to de/hsync_n/vsync_n/rgb is FACE_LAT+1 clocks.
REQ-023 Colour priority: qbert_top_face, then top_face, then left_face, then right_face, then col_bg.
REQ-024 rgb is 0 whenever the delayed visible flag is low, regardless of the face flags.
REQ-025 frame_start and vblank are decoded from the undelayed counters and registered, giving one clock of latency.
REQ-026 Simultaneous face flags are resolved by REQ-023 only; no error is flagged.

Reset
REQ-027 While reset=0, on each clk edge: x_cnt=0, y_cnt=0, all delay stages cleared, hsync_n=1, vsync_n=1, de=0, rgb=0, frame_start=0, vblank=0.
REQ-028 If reset is asserted mid-frame, the block returns to (0,0) on the next edge with no partial-line completion.
REQ-029 The first clock after reset release has x_cnt=0, y_cnt=0, and frame_start pulses one clock later.

Configuration
REQ-030 Macro TEST_PATTERN_EN, when defined, adds input test_mode (1 bit): when test_mode=1, rgb is eight vertical colour bars, each H_ACTIVE/8 pixels wide (white, yellow, cyan, green, magenta, red, blue, black), and the face flags are ignored. The same latency and de gating apply.
REQ-031 Without TEST_PATTERN_EN, the test_mode port does not exist and rgb follows REQ-023 and REQ-024 only.

Structure
REQ-032 The shared package mtl_pkg holds the default timing constants, the 24-bit rgb_t typedef and the colour-bar constants.
REQ-033 One sub-module, mtl_delay_line (parameterised width and depth, with depth 0 meaning a wire), implements the REQ-021 shift register.

Verification
REQ-034 Release reset and run 2 full frames -> x_cnt wraps at 1055 and y_cnt wraps at 524; frame_start occurs every 554400 clocks.
REQ-035 Hold the flags low -> hsync_n is low for 20 clocks starting FACE_LAT+1 clocks after x_cnt=1010; de is high for 800 clocks per visible line.
REQ-036 Drive top_face=1 and qbert_top_face=1 together at x_cnt=100, y_cnt=50, aligned per FACE_LAT -> rgb=col_qbert on that pixel; with top_face only -> rgb=col_top.
REQ-037 Drive left_face=1 during blanking (x_cnt=900) -> rgb=0 and de=0.
REQ-038 Assert reset at x_cnt=400, y_cnt=200 for 1 clock -> the next cycle shows x_cnt=0 and y_cnt=0 with all outputs at their reset values.
REQ-039 With TEST_PATTERN_EN defined and test_mode=1, sample at x_cnt=0, 100 and 799 -> rgb=FFFFFF, FFFF00 and 000000 respectively.
